// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared defaults and index helpers for the round-robin arbitrated mux
package arb_mux_pkg;

   // Default channel count, channel data width and transfer-counter width
   localparam int N_DEF     = 4;
   localparam int W_DEF     = 8;
   localparam int CNT_W_DEF = 16;

   // Channel index width; a single-channel build still needs one bit of index
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Next index after idx in a ring of n entries
   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - request/response bus between N producers, the arbitrated mux and one consumer
interface rr_arb_mux_if
   import arb_mux_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
);

   localparam int SEL_W = sel_w(N);

   // Producer side: channel i owns in_valid[i], in_ready[i] and in_data[i*W +: W]
   logic [N-1:0]     in_valid;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_ready;

   // Consumer side: registered word plus the channel it came from
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_sel;
   logic             out_ready;

   // Environment view: drives the producer requests and the consumer ready
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sel
   );

   // Mux view: accepts the requests and drives the output register
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sel
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting at a pointer
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter  int N     = N_DEF,
   localparam int SEL_W = sel_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             any_grant
);

   // Walk the ring from ptr upward and keep the first requester found
   always_comb begin
      int cand;
      cand      = 0;
      any_grant = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!any_grant && req[SEL_W'(cand)]) begin
            any_grant = 1'b1;
            grant_idx = SEL_W'(cand);
         end
      end
   end

   // One-hot grant, suppressed when the consumer side cannot take a word
   always_comb begin
      grant = '0;
      if (en && any_grant) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin arbitrated mux with registered output; RR_ARB_MUX_COUNT_EN adds xfer_count
module rr_arb_mux
   import arb_mux_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
`ifdef RR_ARB_MUX_COUNT_EN
   ,
   parameter int CNT_W = CNT_W_DEF
`endif
) (
   input logic         clk,
   input logic         reset,
   rr_arb_mux_if.slave bus
`ifdef RR_ARB_MUX_COUNT_EN
   ,
   output logic [CNT_W-1:0] xfer_count
`endif
);

   localparam int SEL_W = sel_w(N);

   logic             load;
   logic             arb_en;
   logic             any_req;
   logic             accept;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] ptr;
   logic [W-1:0]     sel_data;

   logic             out_valid_q;
   logic [W-1:0]     out_data_q;
   logic [SEL_W-1:0] out_sel_q;

   // The output register can take a new word when empty or being drained
   assign load   = !out_valid_q || bus.out_ready;
   assign arb_en = load && !reset;
   assign accept = arb_en && any_req;

   rr_arbiter #(
      .N (N)
   ) u_arbiter (
      .req       (bus.in_valid),
      .ptr       (ptr),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_req)
   );

   // Pick the granted channel's slice; the data path does no arithmetic
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            sel_data = bus.in_data[i*W +: W];
         end
      end
   end

   // Output register and pointer: load on accept, drain to empty when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr         <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= sel_data;
         out_sel_q   <= grant_idx;
         ptr         <= SEL_W'(wrap_inc(int'(grant_idx), N));
      end else if (load) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = grant;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

`ifdef RR_ARB_MUX_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Count every accepted input word, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign xfer_count = cnt_q;
`endif

endmodule
